endeavour_soc: RTL and testbench

ENDEAVOUR_SOC -- requirements
Module: endeavour_soc

---
 rtl/endeavour_soc.sv | 193 +++++++++++++++++++
 tb/tb_endeavour_soc.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endeavour_soc.sv
// Endeavour SoC board-control block: delayed internal reset plus a UART echo path
// (8E1 receiver -> 4-entry FIFO -> 8E1 transmitter) with sticky error LEDs.
module endeavour_soc #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 24_000_000,
  parameter int RESET_DELAY = 3
) (
  input  logic       io_clk_in,
  input  logic       io_nreset,
  input  logic [1:0] io_keys,
  output logic [2:0] io_leds,
  input  logic       io_uart_rx,
  output logic       io_uart_tx
);

  localparam int ACC_W = $clog2(CLK_FREQ + BAUD_RATE) + 1;
  localparam longint LOAD_RAW = longint'(CLK_FREQ / 2) + 2 * longint'(BAUD_RATE);
  localparam longint LOAD_MIN = (LOAD_RAW < longint'(CLK_FREQ - 1)) ? LOAD_RAW : longint'(CLK_FREQ - 1);
  localparam logic [ACC_W-1:0] CLK_V  = ACC_W'(CLK_FREQ);
  localparam logic [ACC_W-1:0] BAUD_V = ACC_W'(BAUD_RATE);
  localparam logic [ACC_W-1:0] LOAD_V = ACC_W'(LOAD_MIN);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_ARM, T_SEND} tx_state_e;

  logic [RESET_DELAY-1:0] r_rst_pipe;
  logic                   w_rst_n;
  logic [1:0]             r_rx_sync, r_key_sync;
  logic                   r_rx_prev, w_rx_bit, w_rx_start, w_rx_tick, w_rx_done, w_par_ok;
  rx_state_e              r_rx_state, w_rx_next;
  logic [ACC_W-1:0]       r_rx_acc, w_rx_sum, r_tx_acc, w_tx_sum;
  logic [2:0]             r_rx_cnt;
  logic [7:0]             r_rx_data;
  logic                   r_rx_par;
  logic [7:0]             r_fifo_mem [4];
  logic [1:0]             r_wr_ptr, r_rd_ptr;
  logic [2:0]             r_fifo_cnt;
  logic                   w_full, w_empty, w_push, w_push_ok, w_pop;
  logic [7:0]             w_fifo_head;
  tx_state_e              r_tx_state, w_tx_next;
  logic                   w_tx_tick, w_tx_last, r_tx_out;
  logic [9:0]             r_tx_shift;
  logic [3:0]             r_tx_cnt;
  logic [2:0]             r_leds, w_set;
  logic                   w_unused_key;

  assign w_unused_key = io_keys[1];

  // Internal reset asserts with io_nreset and releases after RESET_DELAY edges.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge io_clk_in or negedge io_nreset) begin
    if (!io_nreset) r_rst_pipe <= '0;
    else            r_rst_pipe <= (r_rst_pipe << 1) | RESET_DELAY'(1);
  end
  assign w_rst_n = r_rst_pipe[RESET_DELAY-1];

  always_ff @(posedge io_clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_sync  <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_key_sync <= 2'b00;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], io_uart_rx};
      r_rx_prev  <= r_rx_sync[1];
      r_key_sync <= {r_key_sync[0], io_keys[0]};
    end
  end

  assign w_rx_bit   = r_rx_sync[1];
  assign w_rx_start = (r_rx_state == R_IDLE) && r_rx_prev && !w_rx_bit;
  assign w_rx_sum   = r_rx_acc + BAUD_V;
  assign w_rx_tick  = (r_rx_state != R_IDLE) && (w_rx_sum >= CLK_V);
  assign w_rx_done  = (r_rx_state == R_STOP) && w_rx_tick;
  assign w_par_ok   = ((^r_rx_data) == r_rx_par);

  // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      R_IDLE:   if (w_rx_start) w_rx_next = R_START;
      R_START:  if (w_rx_tick) w_rx_next = w_rx_bit ? R_IDLE : R_DATA;
      R_DATA:   if (w_rx_tick && r_rx_cnt == 3'd7) w_rx_next = R_PARITY;
      R_PARITY: if (w_rx_tick) w_rx_next = R_STOP;
      R_STOP:   if (w_rx_tick) w_rx_next = w_rx_bit ? R_IDLE : R_WAIT;
      R_WAIT:   if (w_rx_bit) w_rx_next = R_IDLE;
      default:  w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge io_clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_state <= R_IDLE;
      r_rx_acc   <= '0;
      r_rx_cnt   <= '0;
      r_rx_data  <= '0;
      r_rx_par   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      if (r_rx_state == R_IDLE) begin
        r_rx_acc <= w_rx_start ? LOAD_V : '0;
        r_rx_cnt <= '0;
      end else begin
        r_rx_acc <= w_rx_tick ? (w_rx_sum - CLK_V) : w_rx_sum;
      end
      if (w_rx_tick && r_rx_state == R_DATA) begin
        r_rx_data <= {w_rx_bit, r_rx_data[7:1]};
        r_rx_cnt  <= r_rx_cnt + 3'd1;
      end
      if (w_rx_tick && r_rx_state == R_PARITY) r_rx_par <= w_rx_bit;
    end
  end

  assign w_push      = w_rx_done && w_rx_bit && w_par_ok;
  assign w_full      = (r_fifo_cnt == 3'd4);
  assign w_empty     = (r_fifo_cnt == 3'd0);
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_fifo_head = r_fifo_mem[r_rd_ptr];

  always_ff @(posedge io_clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push_ok, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 3'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 3'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // NOTE: storage needs no reset; the pointers and count alone define emptiness.
  always_ff @(posedge io_clk_in) begin
    if (w_push_ok) r_fifo_mem[r_wr_ptr] <= r_rx_data;
  end

  assign w_tx_sum  = r_tx_acc + BAUD_V;
  assign w_tx_tick = (w_tx_sum >= CLK_V);
  assign w_tx_last = (r_tx_state == T_SEND) && w_tx_tick && (r_tx_cnt == 4'd10);
  assign w_pop     = !w_empty && ((r_tx_state == T_IDLE) || w_tx_last);

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      T_IDLE:  if (!w_empty) w_tx_next = T_ARM;
      T_ARM:   if (w_tx_tick) w_tx_next = T_SEND;
      T_SEND:  if (w_tx_last && w_empty) w_tx_next = T_IDLE;
      default: w_tx_next = T_IDLE;
    endcase
  end

  // A frame popped at the end of a stop bit starts immediately, so streams stay gapless.
  always_ff @(posedge io_clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tx_state <= T_IDLE;
      r_tx_acc   <= '0;
      r_tx_out   <= 1'b1;
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_acc   <= w_tx_tick ? (w_tx_sum - CLK_V) : w_tx_sum;
      if (r_tx_state == T_ARM && w_tx_tick) begin
        r_tx_out <= 1'b0;
        r_tx_cnt <= '0;
      end else if (r_tx_state == T_SEND && w_tx_tick) begin
        if (r_tx_cnt == 4'd10) begin
          r_tx_out <= !w_pop;
          r_tx_cnt <= '0;
        end else begin
          r_tx_out   <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
          r_tx_cnt   <= r_tx_cnt + 4'd1;
        end
      end
      if (w_pop) r_tx_shift <= {1'b1, ^w_fifo_head, w_fifo_head};
    end
  end

  assign w_set = {w_push && w_full && !w_pop, w_rx_done && !w_rx_bit, w_rx_done && w_rx_bit && !w_par_ok};

  always_ff @(posedge io_clk_in or negedge w_rst_n) begin
    if (!w_rst_n) r_leds <= 3'b000;
    else          r_leds <= w_set | (r_key_sync[1] ? 3'b000 : r_leds);
  end

  assign io_leds    = r_leds;
  assign io_uart_tx = r_tx_out;

endmodule

// File: tb/tb_endeavour_soc.sv
// Bench for endeavour_soc: drives 8E1 frames at 24 Mbaud, decodes the echo stream
// and compares it with a byte-level model of which frames should come back.
`timescale 1ns/1ps
module tb_endeavour_soc;

  localparam real BIT_NS = 1.0e9 / 24.0e6;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    realtime    t;
  } echo_t;

  logic       clk = 1'b0;
  logic       io_nreset = 1'b1;
  logic [1:0] io_keys = 2'b00;
  logic [2:0] io_leds;
  logic       io_uart_rx = 1'b1;
  logic       io_uart_tx;

  int      n_cmp = 0;
  int      n_err = 0;
  echo_t   echo_q[$];
  realtime t_stop;
  echo_t   mon_rec;
  realtime mon_t;

  endeavour_soc #(
    .CLK_FREQ   (100_000_000),
    .BAUD_RATE  (24_000_000),
    .RESET_DELAY(3)
  ) dut (
    .io_clk_in (clk),
    .io_nreset (io_nreset),
    .io_keys   (io_keys),
    .io_leds   (io_leds),
    .io_uart_rx(io_uart_rx),
    .io_uart_tx(io_uart_tx)
  );

  always #5 clk = ~clk;

  // Echo decoder: mid-bit sampling from each falling edge of the tx line.
  initial begin
    forever begin
      @(negedge io_uart_tx);
      mon_t = $realtime;
      #(BIT_NS / 2.0);
      if (io_uart_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          #(BIT_NS);
          mon_rec.data[i] = io_uart_tx;
        end
        #(BIT_NS);
        mon_rec.par = io_uart_tx;
        #(BIT_NS);
        mon_rec.stop = io_uart_tx;
        mon_rec.t = mon_t;
        echo_q.push_back(mon_rec);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
    logic [10:0] f;
    f = {stop_v, (^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == 10) t_stop = $realtime;
      io_uart_rx = f[i];
      #(BIT_NS);
    end
  endtask

  task automatic wait_echo(input int n, input int budget, input string name);
    int k = 0;
    while (echo_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    n_cmp++;
    if (echo_q.size() < n) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d echoes, required %0d", name, echo_q.size(), n);
    end
  endtask

  task automatic clear_flags();
    @(negedge clk);
    io_keys[0] = 1'b1;
    repeat (3) @(negedge clk);
    io_keys[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad = 0;
    io_nreset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (io_uart_tx !== 1'b1 || io_leds !== 3'b000) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_outputs: tx=%b leds=%b, required tx=1 leds=000", io_uart_tx, io_leds);
    end
    @(negedge clk);
    io_nreset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (dut.w_rst_n !== (i == 3)) begin
        n_err++;
        $display("FAIL reset_release_edge%0d: internal rst_n=%b, required %b", i, dut.w_rst_n, (i == 3));
      end
      n_cmp++;
      if (io_uart_tx !== 1'b1 || io_leds !== 3'b000) begin
        n_err++;
        $display("FAIL reset_release_out%0d: tx=%b leds=%b, required tx=1 leds=000", i, io_uart_tx, io_leds);
      end
    end
  endtask

  task automatic test_echo_basic();
    echo_t r;
    echo_q.delete();
    repeat (10) @(negedge clk);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_echo(1, 1000, "echo55");
    if (echo_q.size() > 0) begin
      r = echo_q.pop_front();
      n_cmp++;
      if (r.data !== 8'h55 || r.par !== 1'b0 || r.stop !== 1'b1) begin
        n_err++;
        $display("FAIL echo55_frame: data=%h par=%b stop=%b, required 55 0 1", r.data, r.par, r.stop);
      end
      n_cmp++;
      if (r.t <= t_stop || (r.t - t_stop) >= 12.0 * BIT_NS) begin
        n_err++;
        $display("FAIL echo55_latency: %0.1f ns after rx stop, required 0 < t < %0.1f", r.t - t_stop, 12.0 * BIT_NS);
      end
    end
    n_cmp++;
    if (io_leds !== 3'b000) begin
      n_err++;
      $display("FAIL echo55_leds: leds=%b, required 000", io_leds);
    end
  endtask

  task automatic test_parity_error();
    echo_q.delete();
    send_frame(8'hA3, 1'b1, 1'b1);
    #(BIT_NS * 30.0);
    n_cmp++;
    if (echo_q.size() != 0) begin
      n_err++;
      $display("FAIL parity_no_echo: %0d echoes, required 0", echo_q.size());
    end
    n_cmp++;
    if (io_leds !== 3'b001) begin
      n_err++;
      $display("FAIL parity_flag: leds=%b, required 001", io_leds);
    end
    @(negedge clk);
    io_keys[1] = 1'b1;
    repeat (6) @(negedge clk);
    io_keys[1] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (io_leds !== 3'b001) begin
      n_err++;
      $display("FAIL parity_flag_held: leds=%b after key1, required 001", io_leds);
    end
    clear_flags();
    n_cmp++;
    if (io_leds !== 3'b000) begin
      n_err++;
      $display("FAIL parity_clear: leds=%b after key0, required 000", io_leds);
    end
  endtask

  task automatic test_framing_error();
    echo_t r;
    echo_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0);
    #(BIT_NS * 2.0 / 3.0);
    io_uart_rx = 1'b1;
    #(BIT_NS);
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_echo(1, 1000, "framing");
    #(BIT_NS * 15.0);
    n_cmp++;
    if (echo_q.size() != 1) begin
      n_err++;
      $display("FAIL framing_count: %0d echoes, required 1", echo_q.size());
    end
    if (echo_q.size() > 0) begin
      r = echo_q.pop_front();
      n_cmp++;
      if (r.data !== 8'h3C || r.par !== 1'b0 || r.stop !== 1'b1) begin
        n_err++;
        $display("FAIL framing_echo: data=%h par=%b stop=%b, required 3c 0 1", r.data, r.par, r.stop);
      end
    end
    n_cmp++;
    if (io_leds !== 3'b010) begin
      n_err++;
      $display("FAIL framing_flag: leds=%b, required 010", io_leds);
    end
    clear_flags();
  endtask

  task automatic test_back_to_back();
    echo_t r;
    int bad = 0;
    echo_q.delete();
    for (int i = 0; i < 64; i++) send_frame(8'(i), 1'b0, 1'b1);
    io_uart_rx = 1'b1;
    wait_echo(64, 6000, "stream");
    for (int i = 0; i < 64 && echo_q.size() > 0; i++) begin
      r = echo_q.pop_front();
      n_cmp++;
      if (r.data !== 8'(i) || r.par !== ^(8'(i)) || r.stop !== 1'b1) begin
        n_err++;
        bad++;
        if (bad < 5) $display("FAIL stream_byte%0d: data=%h par=%b stop=%b, required %h %b 1", i, r.data, r.par, r.stop, 8'(i), ^(8'(i)));
      end
    end
    n_cmp++;
    if (io_leds !== 3'b000) begin
      n_err++;
      $display("FAIL stream_leds: leds=%b, required 000", io_leds);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic       exp_par_err = 1'b0;
    logic [7:0] d;
    logic       bad;
    echo_t      r;
    echo_q.delete();
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(d, bad, 1'b1);
      if (bad) exp_par_err = 1'b1;
      else     exp_q.push_back(d);
      io_uart_rx = 1'b1;
      #(BIT_NS * real'($urandom_range(0, 3)));
    end
    wait_echo(exp_q.size(), 6000, "random");
    #(BIT_NS * 15.0);
    n_cmp++;
    if (echo_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL random_count: %0d echoes, required %0d", echo_q.size(), exp_q.size());
    end
    while (echo_q.size() > 0 && exp_q.size() > 0) begin
      r = echo_q.pop_front();
      d = exp_q.pop_front();
      n_cmp++;
      if (r.data !== d || r.par !== ^d || r.stop !== 1'b1) begin
        n_err++;
        $display("FAIL random_byte: data=%h par=%b stop=%b, required %h %b 1", r.data, r.par, r.stop, d, ^d);
      end
    end
    n_cmp++;
    if (io_leds !== {2'b00, exp_par_err}) begin
      n_err++;
      $display("FAIL random_leds: leds=%b, required %b", io_leds, {2'b00, exp_par_err});
    end
    clear_flags();
  endtask

  task automatic test_reset_midframe();
    int    bad = 0;
    echo_t r;
    echo_q.delete();
    fork
      send_frame(8'($urandom), 1'b0, 1'b1);
      begin
        #(BIT_NS * 4.5);
        io_nreset = 1'b0;
      end
    join
    io_uart_rx = 1'b1;
    n_cmp++;
    if (io_uart_tx !== 1'b1 || io_leds !== 3'b000) begin
      n_err++;
      $display("FAIL midreset_held: tx=%b leds=%b, required tx=1 leds=000", io_uart_tx, io_leds);
    end
    #(BIT_NS * 2.0);
    @(negedge clk);
    io_nreset = 1'b1;
    repeat (250) begin
      @(negedge clk);
      if (io_uart_tx !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0 || echo_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_no_echo: %0d low tx samples, %0d echoes, required 0 and 0", bad, echo_q.size());
    end
    send_frame(8'hC7, 1'b0, 1'b1);
    io_uart_rx = 1'b1;
    wait_echo(1, 1000, "post_reset");
    if (echo_q.size() > 0) begin
      r = echo_q.pop_front();
      n_cmp++;
      if (r.data !== 8'hC7 || r.par !== 1'b1 || r.stop !== 1'b1) begin
        n_err++;
        $display("FAIL post_reset_echo: data=%h par=%b stop=%b, required c7 1 1", r.data, r.par, r.stop);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_echo_basic();
    test_parity_error();
    test_framing_error();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
